// File: rtl/if_prefetch.sv
// if_prefetch: instruction fetch front end with a small prefetch queue.
// Owns the fetch PC, issues one outstanding request at a time to instruction
// memory, queues returned words and hands {pc, inst} to the core.
// Optional build macro IF_PREFETCH_PERF_CNT_EN adds pop/redirect counters.
//
// Handshakes: a queue entry transfers to the core on a rising edge where
// valid_o & ready_i; a memory response completes on a rising edge where
// inst_ce_o & inst_ready_i (inst_ready_i is meaningless while inst_ce_o=0).
module if_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] inst_addr_o,
  output logic        inst_ce_o,
  input  logic [31:0] inst_i,
  input  logic        inst_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [1:0]  state_o
`ifdef IF_PREFETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          ce_q, ce_d;
  logic [31:0]   addr_q, addr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   qinst_q [DEPTH];
  logic [31:0]   qinst_d [DEPTH];
  logic [31:0]   qpc_q   [DEPTH];
  logic [31:0]   qpc_d   [DEPTH];

  logic          pop;
  logic          resp;
  logic          push;
  logic [31:0]   target;
  logic [31:0]   next_pc;

  assign valid_o     = (count_q != '0);
  assign inst_o      = qinst_q[rd_ptr_q];
  assign pc_o        = qpc_q[rd_ptr_q];
  assign inst_ce_o   = ce_q;
  assign inst_addr_o = addr_q;
  assign state_o     = state_q;

  // Queue bookkeeping: push on accepted response, pop on core handshake, flush on redirect
  always_comb begin
    pop     = valid_o & ready_i;
    resp    = ce_q & inst_ready_i;
    push    = (state_q == S_REQ) & resp & ~redirect_i;
    target  = {redirect_pc_i[31:2], 2'b00};
    next_pc = fetch_pc_q + 32'd4;
    qinst_d = qinst_q;
    qpc_d   = qpc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      qinst_d[wr_ptr_q] = inst_i;
      qpc_d[wr_ptr_q]   = fetch_pc_q;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (redirect_i) begin
      // Flush; a coincident pop has already been consumed by the core.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Fetch FSM: request issue, response accept/discard, redirect handling
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    ce_d       = ce_q;
    addr_d     = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (redirect_i) begin
          fetch_pc_d = target;
          state_d    = S_REQ;
          ce_d       = 1'b1;
          addr_d     = target;
        end else if (count_d < DEPTH_W) begin
          state_d = S_REQ;
          ce_d    = 1'b1;
          addr_d  = fetch_pc_q;
        end
      end
      S_REQ: begin
        if (redirect_i) begin
          fetch_pc_d = target;
          if (resp) begin
            // Outstanding word is dropped; the target goes out next cycle.
            addr_d = target;
          end else begin
            // Cannot withdraw the request: wait for it and throw it away.
            state_d = S_DROP;
          end
        end else if (resp) begin
          fetch_pc_d = next_pc;
          addr_d     = next_pc;
          if (!(count_d < DEPTH_W)) begin
            state_d = S_IDLE;
            ce_d    = 1'b0;
          end
        end
      end
      S_DROP: begin
        if (redirect_i) begin
          fetch_pc_d = target;
        end
        if (resp) begin
          state_d = S_REQ;
          ce_d    = 1'b1;
          addr_d  = redirect_i ? target : fetch_pc_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        ce_d    = 1'b0;
      end
    endcase
  end

  // State, request and queue registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      ce_q       <= 1'b0;
      addr_q     <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        qinst_q[i] <= '0;
        qpc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      ce_q       <= ce_d;
      addr_q     <= addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      qinst_q    <= qinst_d;
      qpc_q      <= qpc_d;
    end
  end

`ifdef IF_PREFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Performance counters: pops delivered and redirect cycles seen
  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {31'd0, pop};
    flush_cnt_d = flush_cnt_q + {31'd0, redirect_i};
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: directed scoreboard bench for if_prefetch.
// Expected {pc, inst} pairs are queued by the stimulus; a negedge monitor
// pops and compares on every valid_o & ready_i handshake.
module tb_if_prefetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic [31:0] inst_addr_o;
  logic        inst_ce_o;
  logic [31:0] inst_i;
  logic        inst_ready_i;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [1:0]  state_o;
`ifdef IF_PREFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_o;
  logic [31:0] flush_cnt_o;
`endif

  // memory model controls
  logic        mem_en = 1'b1;
  int          mem_lat = 0;
  int          wait_cnt = 0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_data = 32'h0;
  logic        man_ready = 1'b0;
  logic [31:0] man_data = 32'h0;

  assign inst_ready_i = mem_en ? mem_ready : man_ready;
  assign inst_i       = mem_en ? mem_data  : man_data;

  if_prefetch #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_addr_o   (inst_addr_o),
    .inst_ce_o     (inst_ce_o),
    .inst_i        (inst_i),
    .inst_ready_i  (inst_ready_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .state_o       (state_o)
`ifdef IF_PREFETCH_PERF_CNT_EN
    ,
    .fetch_cnt_o   (fetch_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
`endif
  );

  // Memory: answers each request after mem_lat wait cycles with data = address
  always begin
    @(posedge clk);
    #1;
    if (inst_ce_o) begin
      if (wait_cnt >= mem_lat) begin
        mem_ready = 1'b1;
        mem_data  = inst_addr_o;
        wait_cnt  = 0;
      end else begin
        mem_ready = 1'b0;
        wait_cnt  = wait_cnt + 1;
      end
    end else begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc, input logic [31:0] inst);
    exp_q.push_back({pc, inst});
  endtask

  always @(negedge clk) begin
    logic [63:0] e;
    if (rst && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pop: got pc=%h inst=%h want no delivery", pc_o, inst_o);
      end else begin
        e = exp_q.pop_front();
        check("pop_pc_inst", {pc_o, inst_o}, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    check("leftover_expected", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    rst           = 1'b0;
    ready_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    man_ready     = 1'b0;
    man_data      = 32'h0;
    mem_en        = 1'b1;
    mem_lat       = 0;
    repeat (2) tick();
  endtask

  task automatic drain();
    int k;
    k = 0;
    ready_i = 1'b1;
    while (exp_q.size() != 0 && k < 300) begin
      tick();
      k++;
    end
    check("drain_done", 64'(exp_q.size() == 0), 64'd1);
    ready_i = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset values and streaming from a zero-wait memory
    do_reset();
    check("rst_ce", 64'(inst_ce_o), 64'd0);
    check("rst_addr", 64'(inst_addr_o), 64'(RESET_PC));
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_inst", 64'(inst_o), 64'd0);
    check("rst_pc", 64'(pc_o), 64'd0);
    check("rst_state", 64'(state_o), 64'd0);
    for (int i = 0; i < 8; i++) expect_pc(32'(i * 4), 32'(i * 4));
    ready_i = 1'b1;
    rst = 1'b1;
    tick();
    check("t1_first_ce", 64'(inst_ce_o), 64'd1);
    check("t1_first_addr", 64'(inst_addr_o), 64'(RESET_PC));
    @(negedge clk);
    check("t1_valid_early", 64'(valid_o), 64'd0);
    tick();
    @(negedge clk);
    check("t1_valid_first", 64'(valid_o), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check("t1_stream_valid", 64'(valid_o), 64'd1);
    end
    drain();

    // Core stalled: fill exactly four, stop, then one pop refetches 0x10
    do_reset();
    rst = 1'b1;
    repeat (8) tick();
    check("t2_ce_idle", 64'(inst_ce_o), 64'd0);
    check("t2_state_idle", 64'(state_o), 64'd0);
    expect_pc(32'h0, 32'h0);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("t2_refetch_ce", 64'(inst_ce_o), 64'd1);
    check("t2_refetch_addr", 64'(inst_addr_o), 64'h10);
    tick();
    check("t2_ce_off", 64'(inst_ce_o), 64'd0);
    tick();
    check("t2_ce_stays_off", 64'(inst_ce_o), 64'd0);
    expect_pc(32'h4, 32'h4);
    expect_pc(32'h8, 32'h8);
    expect_pc(32'hC, 32'hC);
    expect_pc(32'h10, 32'h10);
    drain();

    // Slow memory with a redirect during the wait: request held, then 0x104
    do_reset();
    mem_lat = 2;
    ready_i = 1'b1;
    rst = 1'b1;
    tick();
    check("t3_req_addr", 64'(inst_addr_o), 64'h0);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h104;
    tick();
    redirect_i = 1'b0;
    check("t3_drop_state", 64'(state_o), 64'd2);
    check("t3_hold_ce", 64'(inst_ce_o), 64'd1);
    check("t3_hold_addr", 64'(inst_addr_o), 64'h0);
    tick();
    check("t3_hold_addr2", 64'(inst_addr_o), 64'h0);
    tick();
    check("t3_target_addr", 64'(inst_addr_o), 64'h104);
    check("t3_target_state", 64'(state_o), 64'd1);
    @(negedge clk);
    check("t3_no_stale_valid", 64'(valid_o), 64'd0);
    expect_pc(32'h104, 32'h104);
    expect_pc(32'h108, 32'h108);
    expect_pc(32'h10C, 32'h10C);
    drain();

    // Redirect coincident with response and pop, three entries queued
    do_reset();
    rst = 1'b1;
    repeat (4) tick();
    check("t4_addr_c", 64'(inst_addr_o), 64'hC);
    expect_pc(32'h0, 32'h0);
    ready_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h203;
    tick();
    ready_i = 1'b0;
    redirect_i = 1'b0;
    check("t4_ce", 64'(inst_ce_o), 64'd1);
    check("t4_addr_target", 64'(inst_addr_o), 64'h200);
    @(negedge clk);
    check("t4_flushed", 64'(valid_o), 64'd0);
    expect_pc(32'h200, 32'h200);
    expect_pc(32'h204, 32'h204);
    drain();

    // Reset during an outstanding request, then a late response
    do_reset();
    mem_en = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    check("t5_outstanding", 64'({inst_ce_o, state_o}), 64'({1'b1, 2'd1}));
    rst = 1'b0;
    tick();
    check("t5_rst_ce", 64'(inst_ce_o), 64'd0);
    rst = 1'b1;
    man_ready = 1'b1;
    man_data = 32'hDEAD_BEEF;
    tick();
    man_ready = 1'b0;
    check("t5_restart_ce", 64'(inst_ce_o), 64'd1);
    check("t5_restart_addr", 64'(inst_addr_o), 64'(RESET_PC));
    @(negedge clk);
    check("t5_late_ignored", 64'(valid_o), 64'd0);
    expect_pc(RESET_PC, 32'h1234_5678);
    man_ready = 1'b1;
    man_data = 32'h1234_5678;
    tick();
    man_ready = 1'b0;
    drain();

    // Fetch PC wraps from 0xFFFF_FFFC to 0x0
    do_reset();
    rst = 1'b1;
    tick();
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFE;
    tick();
    redirect_i = 1'b0;
    check("t6_top_addr", 64'(inst_addr_o), 64'hFFFF_FFFC);
    tick();
    check("t6_wrap_addr", 64'(inst_addr_o), 64'h0);
    expect_pc(32'hFFFF_FFFC, 32'hFFFF_FFFC);
    expect_pc(32'h0, 32'h0);
    expect_pc(32'h4, 32'h4);
    drain();

    // Two redirects then ten pops
    do_reset();
    rst = 1'b1;
    repeat (6) tick();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h80;
    tick();
    check("t7_first_target", 64'(inst_addr_o), 64'h80);
    redirect_pc_i = 32'h40;
    tick();
    redirect_i = 1'b0;
    check("t7_second_target", 64'(inst_addr_o), 64'h40);
    for (int i = 0; i < 10; i++) expect_pc(32'h40 + 32'(i * 4), 32'h40 + 32'(i * 4));
    drain();
`ifdef IF_PREFETCH_PERF_CNT_EN
    check("t7_fetch_cnt", 64'(fetch_cnt_o), 64'd10);
    check("t7_flush_cnt", 64'(flush_cnt_o), 64'd2);
`endif

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
